multicycle_control: RTL and testbench

- Sequencing control FSM for the multicycle RV32I datapath.
- Replaces single-cycle opcode decode with a state machine that steps each instruction through FETCH/DECODE/EXECUTE/MEM/WB.
- Handles variable-latency memory through a req/ready handshake, with a configurable timeout.
- Adds optional JAL/JALR support, sticky error flags and a retired-instruction counter.

---
 rtl/mc_ctrl_pkg.sv | 38 +++
 rtl/mc_mem_timeout.sv | 33 +++
 rtl/multicycle_control.sv | 183 ++++++++++++++++++
 tb/tb_multicycle_control.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// Shared types and encodings for the multicycle RV32I sequencing controller.
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_JALR, S_TRAP
  } state_t;

  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  localparam logic [1:0] ASRC_PC    = 2'b00;
  localparam logic [1:0] ASRC_OLDPC = 2'b01;
  localparam logic [1:0] ASRC_RS1   = 2'b10;

  localparam logic [1:0] BSRC_RS2   = 2'b00;
  localparam logic [1:0] BSRC_FOUR  = 2'b01;
  localparam logic [1:0] BSRC_IMM   = 2'b10;

  localparam logic [1:0] PCSRC_ALU      = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT   = 2'b01;
  localparam logic [1:0] PCSRC_ALU_CLR0 = 2'b10;

  localparam logic [1:0] WB_ALUOUT = 2'b00;
  localparam logic [1:0] WB_MDR    = 2'b01;
  localparam logic [1:0] WB_PC     = 2'b10;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;
  localparam logic [1:0] ALUOP_I   = 2'b11;

endpackage

// File: rtl/mc_mem_timeout.sv
// Counts consecutive stalled memory cycles and pulses o_timeout on the
// MEM_TIMEOUT-th one; collapses to a constant 0 when MEM_TIMEOUT is 0.
module mc_mem_timeout #(
  parameter int MEM_TIMEOUT = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_stall,
  output logic o_timeout
);

  generate
    if (MEM_TIMEOUT == 0) begin : g_off
      logic w_unused;
      assign w_unused  = &{1'b0, clk, rst_n, i_stall};
      assign o_timeout = 1'b0;
    end else begin : g_on
      localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);
      logic [CW-1:0] r_cnt;

      // A stall always holds the state, so clearing on !i_stall also covers
      // every state change.
      always_ff @(posedge clk) begin
        if (!rst_n)       r_cnt <= '0;
        else if (i_stall) r_cnt <= r_cnt + CW'(1);
        else              r_cnt <= '0;
      end

      assign o_timeout = i_stall && (r_cnt == CW'(MEM_TIMEOUT - 1));
    end
  endgenerate

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the multicycle RV32I datapath: steps each instruction
// through fetch/decode/execute/memory/write-back with a req/ready memory port.
module multicycle_control import mc_ctrl_pkg::*; #(
  parameter int OPCODE_W     = 7,
  parameter int MEM_TIMEOUT  = 0,
  parameter int SUPPORT_JUMP = 1,
  parameter int CNT_W        = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                branch_taken,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic                iord,
  output logic                ir_write,
  output logic                mdr_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic [1:0]          alusrc_a,
  output logic [1:0]          alusrc_b,
  output logic [1:0]          aluop,
  output logic                regwrite,
  output logic [1:0]          wb_sel,
  output logic                instr_done,
  output logic                illegal,
  output logic                bus_error,
  output logic [CNT_W-1:0]    retired,
  output state_t              dbg_state
);

  state_t             r_state, w_next;
  logic               r_illegal, r_bus_error;
  logic [CNT_W-1:0]   r_retired;
  logic               w_stall, w_timeout, w_set_illegal;
  state_t             w_end_next;

  assign w_stall = ((r_state == S_FETCH) || (r_state == S_MEM_RD) ||
                    (r_state == S_MEM_WR)) && !mem_ready;
  assign w_end_next = run ? S_FETCH : S_IDLE;

  mc_mem_timeout #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timeout (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_stall  (w_stall),
    .o_timeout(w_timeout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_illegal   <= 1'b0;
      r_bus_error <= 1'b0;
      r_retired   <= '0;
    end else begin
      r_state <= w_next;
      if (w_set_illegal) r_illegal   <= 1'b1;
      if (w_timeout)     r_bus_error <= 1'b1;
      if (instr_done)    r_retired   <= r_retired + CNT_W'(1);
    end
  end

  always_comb begin
    w_next        = r_state;
    w_set_illegal = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    pc_write      = 1'b0;
    pc_src        = PCSRC_ALU;
    alusrc_a      = ASRC_PC;
    alusrc_b      = BSRC_RS2;
    aluop         = ALUOP_ADD;
    regwrite      = 1'b0;
    wb_sel        = WB_ALUOUT;
    instr_done    = 1'b0;
    case (r_state)
      S_IDLE: if (run) w_next = S_FETCH;
      S_FETCH: begin
        mem_req  = 1'b1;
        alusrc_b = BSRC_FOUR;
        ir_write = mem_ready;
        pc_write = mem_ready;
        if (w_timeout)      w_next = S_TRAP;
        else if (mem_ready) w_next = S_DECODE;
      end
      S_DECODE: begin
        // OldPC + imm lands in ALUOut for branch and JAL targets.
        alusrc_a = ASRC_OLDPC;
        alusrc_b = BSRC_IMM;
        if (opcode == OPCODE_W'(OP_RTYPE))                            w_next = S_EXEC_R;
        else if (opcode == OPCODE_W'(OP_ITYPE))                       w_next = S_EXEC_I;
        else if (opcode == OPCODE_W'(OP_LOAD) ||
                 opcode == OPCODE_W'(OP_STORE))                       w_next = S_MEM_ADDR;
        else if (opcode == OPCODE_W'(OP_BRANCH))                      w_next = S_BRANCH;
        else if (SUPPORT_JUMP != 0 && opcode == OPCODE_W'(OP_JAL))    w_next = S_JAL;
        else if (SUPPORT_JUMP != 0 && opcode == OPCODE_W'(OP_JALR))   w_next = S_JALR;
        else begin
          w_set_illegal = 1'b1;
          w_next        = S_TRAP;
        end
      end
      S_EXEC_R: begin
        alusrc_a = ASRC_RS1;
        aluop    = ALUOP_R;
        w_next   = S_WB_ALU;
      end
      S_EXEC_I: begin
        alusrc_a = ASRC_RS1;
        alusrc_b = BSRC_IMM;
        aluop    = ALUOP_I;
        w_next   = S_WB_ALU;
      end
      S_MEM_ADDR: begin
        alusrc_a = ASRC_RS1;
        alusrc_b = BSRC_IMM;
        w_next   = (opcode == OPCODE_W'(OP_LOAD)) ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_req   = 1'b1;
        iord      = 1'b1;
        mdr_write = mem_ready;
        if (w_timeout)      w_next = S_TRAP;
        else if (mem_ready) w_next = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_req = 1'b1;
        mem_we  = 1'b1;
        iord    = 1'b1;
        if (w_timeout) w_next = S_TRAP;
        else if (mem_ready) begin
          instr_done = 1'b1;
          w_next     = w_end_next;
        end
      end
      S_WB_ALU, S_WB_MEM: begin
        regwrite   = 1'b1;
        wb_sel     = (r_state == S_WB_MEM) ? WB_MDR : WB_ALUOUT;
        instr_done = 1'b1;
        w_next     = w_end_next;
      end
      S_BRANCH: begin
        alusrc_a   = ASRC_RS1;
        aluop      = ALUOP_BR;
        pc_src     = PCSRC_ALUOUT;
        pc_write   = branch_taken;
        instr_done = 1'b1;
        w_next     = w_end_next;
      end
      S_JAL: begin
        regwrite   = 1'b1;
        wb_sel     = WB_PC;
        pc_write   = 1'b1;
        pc_src     = PCSRC_ALUOUT;
        instr_done = 1'b1;
        w_next     = w_end_next;
      end
      S_JALR: begin
        // Link value is read from PC before the same edge overwrites it.
        alusrc_a   = ASRC_RS1;
        alusrc_b   = BSRC_IMM;
        pc_src     = PCSRC_ALU_CLR0;
        pc_write   = 1'b1;
        regwrite   = 1'b1;
        wb_sel     = WB_PC;
        instr_done = 1'b1;
        w_next     = w_end_next;
      end
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_IDLE;
    endcase
  end

  assign illegal   = r_illegal;
  assign bus_error = r_bus_error;
  assign retired   = r_retired;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: one default instance and one with
// MEM_TIMEOUT=4, SUPPORT_JUMP=0, sharing the input stimulus.
module tb_multicycle_control;
  import mc_ctrl_pkg::*;

  localparam int W = 22;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, run, branch_taken, mem_ready;
  logic [6:0] opcode;

  logic        req0, we0, iord0, irw0, mdrw0, pcw0, rw0, done0, ill0, berr0;
  logic [1:0]  pcs0, asa0, asb0, aop0, wbs0;
  logic [31:0] ret0;
  state_t      st0;
  logic        req1, we1, iord1, irw1, mdrw1, pcw1, rw1, done1, ill1, berr1;
  logic [1:0]  pcs1, asa1, asb1, aop1, wbs1;
  logic [31:0] ret1;
  state_t      st1;

  multicycle_control dut0 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(req0), .mem_we(we0), .iord(iord0), .ir_write(irw0),
    .mdr_write(mdrw0), .pc_write(pcw0), .pc_src(pcs0), .alusrc_a(asa0),
    .alusrc_b(asb0), .aluop(aop0), .regwrite(rw0), .wb_sel(wbs0),
    .instr_done(done0), .illegal(ill0), .bus_error(berr0), .retired(ret0),
    .dbg_state(st0)
  );

  multicycle_control #(.MEM_TIMEOUT(4), .SUPPORT_JUMP(0)) dut1 (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode),
    .branch_taken(branch_taken), .mem_ready(mem_ready),
    .mem_req(req1), .mem_we(we1), .iord(iord1), .ir_write(irw1),
    .mdr_write(mdrw1), .pc_write(pcw1), .pc_src(pcs1), .alusrc_a(asa1),
    .alusrc_b(asb1), .aluop(aop1), .regwrite(rw1), .wb_sel(wbs1),
    .instr_done(done1), .illegal(ill1), .bus_error(berr1), .retired(ret1),
    .dbg_state(st1)
  );

  logic [W-1:0] obs0, obs1;
  assign obs0 = {st0, req0, we0, iord0, irw0, mdrw0, pcw0, pcs0, asa0, asb0,
                 aop0, rw0, wbs0, done0};
  assign obs1 = {st1, req1, we1, iord1, irw1, mdrw1, pcw1, pcs1, asa1, asb1,
                 aop1, rw1, wbs1, done1};

  logic [W-1:0] exp_q[$];
  state_t       seq_s[$];
  int           n_cmp = 0;
  int           n_bad = 0;

  // Expected control vector for a state, from the published control table.
  function automatic logic [W-1:0] ev(state_t s, logic rdy, logic bt);
    logic       req, we, io, irw, mdrw, pcw, rw, done;
    logic [1:0] pcs, a, b, aop, wbs;
    {req, we, io, irw, mdrw, pcw, rw, done} = '0;
    {pcs, a, b, aop, wbs} = '0;
    case (s)
      S_FETCH:    begin req = 1; irw = rdy; pcw = rdy; b = 2'b01; end
      S_DECODE:   begin a = 2'b01; b = 2'b10; end
      S_EXEC_R:   begin a = 2'b10; aop = 2'b10; end
      S_EXEC_I:   begin a = 2'b10; b = 2'b10; aop = 2'b11; end
      S_MEM_ADDR: begin a = 2'b10; b = 2'b10; end
      S_MEM_RD:   begin req = 1; io = 1; mdrw = rdy; end
      S_MEM_WR:   begin req = 1; we = 1; io = 1; done = rdy; end
      S_WB_ALU:   begin rw = 1; done = 1; end
      S_WB_MEM:   begin rw = 1; wbs = 2'b01; done = 1; end
      S_BRANCH:   begin a = 2'b10; aop = 2'b01; pcs = 2'b01; pcw = bt; done = 1; end
      S_JAL:      begin rw = 1; wbs = 2'b10; pcw = 1; pcs = 2'b01; done = 1; end
      S_JALR:     begin a = 2'b10; b = 2'b10; pcs = 2'b10; pcw = 1; rw = 1; wbs = 2'b10; done = 1; end
      default:    ;
    endcase
    return {s, req, we, io, irw, mdrw, pcw, pcs, a, b, aop, rw, wbs, done};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, compare at the falling edge, advance.
  task automatic step(input int sel, input logic rdy, input logic bt, input string tag);
    logic [W-1:0] o, e;
    mem_ready    = rdy;
    branch_taken = bt;
    @(negedge clk);
    o = (sel != 0) ? obs1 : obs0;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL %s: observed %0h expected <queue empty>", tag, o);
    end else begin
      e = exp_q.pop_front();
      n_cmp++;
      assert (o === e) else begin
        n_bad++;
        $error("FAIL %s: observed %0h expected %0h", tag, o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  // Queue the expected vectors for seq_s, then play the stimulus.
  task automatic run_seq(input int sel, input string tag,
                         input logic [15:0] stall, input logic [15:0] bt);
    int n = seq_s.size();
    for (int i = 0; i < n; i++) exp_q.push_back(ev(seq_s[i], !stall[i], bt[i]));
    for (int i = 0; i < n; i++) step(sel, !stall[i], bt[i], $sformatf("%s[%0d]", tag, i));
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; opcode = OP_RTYPE; mem_ready = 1'b1; branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("rst_retired0", ret0, 32'd0);
    chk("rst_illegal0", {31'd0, ill0}, 32'd0);
    chk("rst_buserr0", {31'd0, berr0}, 32'd0);
    chk("rst_retired1", ret1, 32'd0);
    seq_s = '{S_IDLE};  run_seq(0, "idle0", 16'h0, 16'h0);
    seq_s = '{S_IDLE};  run_seq(1, "idle1", 16'h0, 16'h0);

    run = 1'b1; opcode = OP_RTYPE;
    seq_s = '{S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU};
    run_seq(0, "r_type", 16'h0, 16'h0);
    chk("retired_r", ret0, 32'd1);

    opcode = OP_ITYPE;
    seq_s = '{S_FETCH, S_DECODE, S_EXEC_I, S_WB_ALU};
    run_seq(0, "i_type", 16'h0, 16'h0);

    opcode = OP_LOAD;
    seq_s = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_WB_MEM};
    run_seq(0, "lw_stall", 16'h0038, 16'h0);
    chk("retired_lw", ret0, 32'd3);

    opcode = OP_STORE;
    seq_s = '{S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR, S_MEM_WR};
    run_seq(0, "sw_stall", 16'h0031, 16'h0);

    opcode = OP_BRANCH;
    seq_s = '{S_FETCH, S_DECODE, S_BRANCH};
    run_seq(0, "beq_nt", 16'h0, 16'h0);
    run_seq(0, "beq_t", 16'h0, 16'h0004);
    chk("retired_br", ret0, 32'd6);

    opcode = OP_JAL;
    seq_s = '{S_FETCH, S_DECODE, S_JAL};
    run_seq(0, "jal", 16'h0, 16'h0);

    run = 1'b0; opcode = OP_JALR;
    seq_s = '{S_FETCH, S_DECODE, S_JALR, S_IDLE, S_IDLE};
    run_seq(0, "jalr_stop", 16'h0, 16'h0);
    chk("retired_jalr", ret0, 32'd8);

    run = 1'b1; opcode = OP_RTYPE;
    seq_s = '{S_IDLE, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_FETCH,
              S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_EXEC_R, S_WB_ALU};
    run_seq(0, "no_timeout", 16'h07FE, 16'h0);
    chk("no_timeout_berr", {31'd0, berr0}, 32'd0);
    chk("retired_long", ret0, 32'd9);

    opcode = OP_STORE;
    seq_s = '{S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_WR, S_MEM_WR};
    run_seq(0, "sw_pre_rst", 16'h0018, 16'h0);
    rst_n = 1'b0;
    seq_s = '{S_MEM_WR};
    run_seq(0, "sw_rst_cyc", 16'h0001, 16'h0);
    rst_n = 1'b1;
    chk("rst_mid_retired", ret0, 32'd0);
    opcode = 7'b0110111;
    seq_s = '{S_IDLE, S_FETCH, S_DECODE, S_TRAP};
    run_seq(0, "illegal", 16'h0, 16'h0);
    chk("illegal_set", {31'd0, ill0}, 32'd1);
    run = 1'b0;
    seq_s = '{S_TRAP};  run_seq(0, "trap_run0", 16'h0, 16'h0);
    run = 1'b1;
    seq_s = '{S_TRAP};  run_seq(0, "trap_run1", 16'h0, 16'h0);
    chk("trap_retired", ret0, 32'd0);
    rst_n = 1'b0;
    seq_s = '{S_TRAP};  run_seq(0, "trap_rst_cyc", 16'h0, 16'h0);
    rst_n = 1'b1; run = 1'b0;
    seq_s = '{S_IDLE};  run_seq(0, "post_trap_idle", 16'h0, 16'h0);
    chk("illegal_clr", {31'd0, ill0}, 32'd0);

    run = 1'b1; opcode = OP_JAL;
    seq_s = '{S_IDLE, S_FETCH, S_DECODE, S_TRAP, S_TRAP};
    run_seq(1, "jal_nojump", 16'h0, 16'h0);
    chk("jal_nojump_ill", {31'd0, ill1}, 32'd1);
    chk("jal_nojump_berr", {31'd0, berr1}, 32'd0);
    rst_n = 1'b0; run = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("ill1_clr", {31'd0, ill1}, 32'd0);

    run = 1'b1; opcode = OP_RTYPE;
    seq_s = '{S_IDLE, S_FETCH, S_FETCH, S_FETCH};
    run_seq(1, "to_pre", 16'h000E, 16'h0);
    chk("to_pre_berr", {31'd0, berr1}, 32'd0);
    seq_s = '{S_FETCH, S_TRAP};
    run_seq(1, "to_hit", 16'h0003, 16'h0);
    chk("to_berr_set", {31'd0, berr1}, 32'd1);
    run = 1'b0;
    seq_s = '{S_TRAP};  run_seq(1, "to_trap_run0", 16'h0001, 16'h0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("berr1_clr", {31'd0, berr1}, 32'd0);

    run = 1'b1; opcode = OP_LOAD;
    seq_s = '{S_IDLE, S_FETCH, S_FETCH, S_FETCH, S_FETCH, S_DECODE, S_MEM_ADDR,
              S_MEM_RD, S_MEM_RD, S_MEM_RD, S_MEM_RD, S_WB_MEM};
    run_seq(1, "to_edge", 16'h038E, 16'h0);
    chk("to_edge_berr", {31'd0, berr1}, 32'd0);
    chk("to_edge_retired", ret1, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
